// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and default sizing for the TDM demultiplexer.
//   tdm_state_e : framing FSM states (HUNT searching for sync, LOCKED aligned)
//   DEF_W/DEF_N : default word width and channel count
package tdm_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_N = 4;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index within a TDM frame.
//   clk, rst_n : clock, async active-low reset (counter -> 0)
//   i_clr      : force slot 0 (highest priority)
//   i_load1    : load slot 1 (a beat was just captured as slot 0)
//   i_en       : advance by one, wrapping N-1 -> 0
//   o_slot     : current slot
module tdm_slot_counter #(
  parameter int N  = 4,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_load1,
  input  logic          i_en,
  output logic [SW-1:0] o_slot
);

  logic [SW-1:0] r_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_slot <= '0;
    else if (i_clr)                  r_slot <= '0;
    else if (i_load1)                r_slot <= SW'(1);
    else if (i_en) begin
      if (r_slot == SW'(N - 1))      r_slot <= '0;
      else                           r_slot <= r_slot + SW'(1);
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: splits a TDM beat stream into N per-channel holding registers.
//   clk, rst_n  : clock, async active-low reset
//   in_valid    : beat present
//   in_sync     : beat is slot 0 of a frame (only meaningful with in_valid)
//   in_data     : beat payload, W bits
//   out_data    : channel k held at [k*W +: W]
//   out_valid   : per-channel one-cycle update pulse (1 cycle after the beat)
//   frame_done  : pulses with out_valid[N-1]
//   locked      : FSM is LOCKED
//   sync_err    : one-cycle pulse on a framing violation
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic           in_sync,
  input  logic [W-1:0]   in_data,
  output logic [N*W-1:0] out_data,
  output logic [N-1:0]   out_valid,
  output logic           frame_done,
  output logic           locked,
  output logic           sync_err
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  tdm_state_e            r_state;
  logic [N-1:0][W-1:0]   r_ch;
  logic [N-1:0]          r_valid;
  logic                  r_fdone;
  logic                  r_err;

  logic [SW-1:0]         w_slot;
  logic                  w_wr_en;
  logic [SW-1:0]         w_wr_idx;
  logic                  w_err;
  logic                  w_adv;
  logic                  w_load1;
  logic                  w_clr;
  tdm_state_e            w_nxt;

  tdm_slot_counter #(.N(N), .SW(SW)) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_load1 (w_load1),
    .i_en    (w_adv),
    .o_slot  (w_slot)
  );

  // Per-beat framing decision. Any sync beat (in HUNT, at slot 0, or early)
  // lands in channel 0 and reloads the counter to 1; only an unsynced beat at
  // slot 0 while locked is dropped and sends us back to HUNT.
  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_idx = '0;
    w_err    = 1'b0;
    w_adv    = 1'b0;
    w_load1  = 1'b0;
    w_clr    = 1'b0;
    w_nxt    = r_state;
    if (in_valid) begin
      if (r_state == HUNT) begin
        if (in_sync) begin
          w_wr_en = 1'b1;
          w_load1 = 1'b1;
          w_nxt   = LOCKED;
        end
      end else if (in_sync) begin
        w_wr_en = 1'b1;
        w_load1 = 1'b1;
        w_err   = (w_slot != '0);
      end else if (w_slot == '0) begin
        w_err = 1'b1;
        w_clr = 1'b1;
        w_nxt = HUNT;
      end else begin
        w_wr_en  = 1'b1;
        w_wr_idx = w_slot;
        w_adv    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_ch    <= '0;
      r_valid <= '0;
      r_fdone <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_err   <= w_err;
      r_valid <= w_wr_en ? (N'(1) << w_wr_idx) : '0;
      r_fdone <= w_wr_en && (w_wr_idx == SW'(N - 1));
      if (w_wr_en) r_ch[w_wr_idx] <= in_data;
    end
  end

  assign out_data   = r_ch;
  assign out_valid  = r_valid;
  assign frame_done = r_fdone;
  assign locked     = (r_state == LOCKED);
  assign sync_err   = r_err;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a frame-level model.
module tb_tdm_demux;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_sync = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic           frame_done, locked, sync_err;

  tdm_demux #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sync(in_sync),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Model: the frame as plain ints/arrays.
  bit                  m_lock;
  int                  m_slot;
  logic [N-1:0][W-1:0] m_ch;
  logic [N-1:0]        e_valid;
  logic                e_fd, e_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic void model_reset();
    m_lock = 0; m_slot = 0; m_ch = '0; e_valid = '0; e_fd = 0; e_err = 0;
  endfunction

  function automatic void model_step();
    int wr;
    e_valid = '0; e_fd = 0; e_err = 0;
    if (!rst_n) begin model_reset(); return; end
    if (!in_valid) return;
    wr = -1;
    if (!m_lock) begin
      if (in_sync) begin wr = 0; m_lock = 1; end
    end else if (in_sync) begin
      e_err = (m_slot != 0);
      wr = 0;
    end else if (m_slot == 0) begin
      e_err = 1; m_lock = 0;
    end else begin
      wr = m_slot;
    end
    if (wr >= 0) begin
      m_ch[wr] = in_data;
      e_valid[wr] = 1'b1;
      e_fd = (wr == N - 1);
      m_slot = (wr + 1) % N;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_data",   64'(out_data),   64'(m_ch));
      chk("out_valid",  64'(out_valid),  64'(e_valid));
      chk("frame_done", 64'(frame_done), 64'(e_fd));
      chk("locked",     64'(locked),     64'(m_lock));
      chk("sync_err",   64'(sync_err),   64'(e_err));
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic beat(input bit v, input bit s, input logic [W-1:0] d);
    in_valid = v; in_sync = s; in_data = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, 0, W'($urandom));
  endtask

  logic [W-1:0] ch0;

  initial begin
    model_reset();
    #1;
    chk("reset out_data", 64'(out_data), 64'h0);
    chk("reset locked",   64'(locked),   64'h0);
    @(negedge clk);
    chk_en = 1'b1;
    idle(2);
    rst_n = 1'b1;

    // Reset then lock: first frame.
    beat(1, 1, 8'h11); chk("lock v0", 64'(out_valid), 64'h1);
    beat(1, 0, 8'h22); chk("lock v1", 64'(out_valid), 64'h2);
    beat(1, 0, 8'h33); chk("lock v2", 64'(out_valid), 64'h4);
    beat(1, 0, 8'h44); chk("lock v3", 64'(out_valid), 64'h8);
    chk("lock fd", 64'(frame_done), 64'h1);
    chk("lock data", 64'(out_data), 64'h44332211);

    // Missing sync at slot 0.
    beat(1, 0, 8'h55);
    chk("miss err", 64'(sync_err), 64'h1);
    chk("miss locked", 64'(locked), 64'h0);
    ch0 = out_data[7:0];
    chk("miss ch0", 64'(ch0), 64'h11);

    // Hunt discards unsynced beats.
    beat(1, 0, 8'hAA); chk("hunt v", 64'(out_valid), 64'h0);
    beat(1, 0, 8'hBB); chk("hunt err", 64'(sync_err), 64'h0);
    chk("hunt data", 64'(out_data), 64'h44332211);
    beat(1, 1, 8'h01);
    chk("hunt cap", 64'(out_data), 64'h44332201);
    chk("hunt locked", 64'(locked), 64'h1);

    // Early sync at slot 2.
    beat(1, 0, 8'h02);
    beat(1, 1, 8'h77);
    chk("early err", 64'(sync_err), 64'h1);
    ch0 = out_data[7:0];
    chk("early ch0", 64'(ch0), 64'h77);
    chk("early locked", 64'(locked), 64'h1);
    beat(1, 0, 8'h88); chk("early next", 64'(out_valid), 64'h2);
    beat(1, 0, 8'h99);
    beat(1, 0, 8'hAB); chk("early fd", 64'(frame_done), 64'h1);
    chk("early data", 64'(out_data), 64'hAB998877);

    // Stalled frame.
    beat(1, 1, 8'h11); idle(3);
    beat(1, 0, 8'h22); idle(3);
    beat(1, 0, 8'h33); idle(3);
    beat(1, 0, 8'h44); chk("stall fd", 64'(frame_done), 64'h1);
    idle(1);
    chk("stall data", 64'(out_data), 64'h44332211);
    chk("stall quiet", 64'(out_valid), 64'h0);

    // Reset mid-frame, asserted away from any edge.
    beat(1, 1, 8'hC0);
    beat(1, 0, 8'hC1);
    in_valid = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async data",   64'(out_data),  64'h0);
    chk("async valid",  64'(out_valid), 64'h0);
    chk("async locked", 64'(locked),    64'h0);
    @(negedge clk);
    idle(1);
    rst_n = 1'b1;
    beat(1, 0, 8'h5A);
    chk("post rst v", 64'(out_valid), 64'h0);
    chk("post rst lk", 64'(locked), 64'h0);

    // Randomized traffic: sync biased toward frame starts so frames complete.
    for (int i = 0; i < 600; i++) begin
      bit v, s;
      v = ($urandom_range(0, 9) < 7);
      if (m_lock && m_slot == 0) s = ($urandom_range(0, 9) < 8);
      else                        s = ($urandom_range(0, 9) < 2);
      beat(v, s, W'($urandom));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter W, default 8, width of one data word.
REQ-002 Parameter N, default 4, number of channels/slots per frame; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  a data beat is present this cycle.
REQ-006 in_sync  input  1  marks the beat as slot 0 of a frame; ignored when in_valid=0.
REQ-007 in_data  input  W  beat payload.
REQ-008 out_data  output  N*W  per-channel holding registers, channel k at bits [k*W +: W].
REQ-009 out_valid  output  N  one-cycle pulse per channel, bit k high the cycle after channel k is updated.
REQ-010 frame_done  output  1  one-cycle pulse, coincident with out_valid[N-1].
REQ-011 locked  output  1  high while the FSM is in LOCKED.
REQ-012 sync_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-013 The FSM SHALL have two states, HUNT and LOCKED, plus a slot counter of ceil(log2(N)) bits.
REQ-014 In HUNT, beats without in_sync SHALL be discarded with no output change and no sync_err.
REQ-015 In HUNT, a beat with in_sync=1 SHALL be captured as slot 0, move the FSM to LOCKED, and set the slot counter to 1.
REQ-016 In LOCKED, each beat SHALL be written to channel[slot] and advance the slot counter.
REQ-017 The slot counter SHALL wrap from N-1 to 0.
REQ-018 A beat at slot 0 with in_sync=1 SHALL be accepted normally.
REQ-019 A beat at slot 0 with in_sync=0 SHALL be discarded, pulse sync_err, and return the FSM to HUNT.
REQ-020 A beat at slot k!=0 with in_sync=1 SHALL pulse sync_err, be captured as slot 0, and set the slot counter to 1; the FSM stays LOCKED.
REQ-021 Cycles with in_valid=0 SHALL change no state and produce no pulses; frames may stall arbitrarily.
REQ-022 Latency SHALL be 1 cycle: out_data and out_valid reflect a beat on the edge after it is presented.
REQ-023 Channels not written in a cycle SHALL hold their previous value.
REQ-024 sync_err, out_valid and frame_done SHALL each be registered single-cycle pulses.
REQ-025 frame_done SHALL pulse only when slot N-1 is written, including when that write follows a realign.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately clear out_data, out_valid, frame_done, locked, sync_err and the slot counter, and force HUNT.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release, the FSM SHALL require a fresh in_sync.
REQ-028 The first clock edge after rst_n deasserts SHALL process input normally.

Structure
REQ-029 Package tdm_pkg SHALL hold the state enum (HUNT, LOCKED) and the default W/N constants.
REQ-030 The slot counter SHALL be a sub-module, tdm_slot_counter, with enable, load-to-1 and wrap-at-N-1 behaviour.

Verification
REQ-031 The bench SHALL cover a reset-then-lock scenario: N=4, beats sync+0x11, 0x22, 0x33, 0x44 on consecutive cycles -> out_valid = 0001, 0010, 0100, 1000 on cycles 1-4, frame_done with the last pulse, out_data = 0x44332211.
REQ-032 The bench SHALL cover a hunt-discard scenario: beats 0xAA, 0xBB without sync, then sync+0x01 -> no output until 0x01 is captured in channel 0, and locked rises the cycle after.
REQ-033 The bench SHALL cover a stall scenario: a frame with in_valid=0 gaps of 3 cycles between beats -> same final out_data as REQ-031 and no extra pulses.
REQ-034 The bench SHALL cover a missing-sync scenario: after a complete frame, a slot-0 beat 0x55 without sync -> sync_err pulse, locked=0, channel 0 unchanged.
REQ-035 The bench SHALL cover an early-sync scenario: a sync beat 0x77 at slot 2 -> sync_err pulse, channel 0 = 0x77, next beat lands in channel 1, and locked stays 1.
REQ-036 The bench SHALL cover a reset-mid-frame scenario: rst_n low after slot 1 -> all outputs 0 asynchronously; after release, a beat without sync is ignored.
